four_input_stimulus_gen: RTL and testbench



---
 rtl/four_input_stimulus_gen.sv | 122 ++++++++++++
 tb/tb_four_input_stimulus_gen.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/four_input_stimulus_gen.sv
// Clocked sweep of all 16 a/b/c/d vectors into a four-input AND gate, with start/done handshake.
// Define FOUR_INPUT_STIM_CHECK_EN to enable the expected-AND compare driving err/err_count.
module four_input_stimulus_gen #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  input  logic       e,
  output logic [3:0] vec_idx,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [4:0] err_count
);

  // State bits double as the registered busy/done outputs.
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  logic [1:0] state_q, state_d;
  logic [3:0] vec_q, vec_d;
  logic [7:0] hold_q, hold_d;
  logic       accept, last_hold;

  assign accept    = (state_q == S_IDLE) && start;
  assign last_hold = (state_q == S_RUN) && (hold_q == HOLD_LAST);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          vec_d   = 4'd0;
          hold_d  = 8'd0;
        end
      end
      S_RUN: begin
        if (last_hold) begin
          hold_d = 8'd0;
          if (vec_q == 4'hF) begin
            state_d = S_DONE;
            vec_d   = 4'd0;
          end else begin
            vec_d = vec_q + 4'd1;
          end
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        vec_d   = 4'd0;
        hold_d  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= 4'd0;
      hold_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      hold_q  <= hold_d;
    end
  end

  assign {a, b, c, d} = vec_q;
  assign vec_idx      = vec_q;
  assign busy         = state_q[0];
  assign done         = state_q[1];

`ifdef FOUR_INPUT_STIM_CHECK_EN
  logic       err_q, err_d;
  logic [4:0] cnt_q, cnt_d;

  // Expected gate output is 1 only for the all-ones vector.
  always_comb begin
    err_d = err_q;
    cnt_d = cnt_q;
    if (accept) begin
      err_d = 1'b0;
      cnt_d = 5'd0;
    end else if (last_hold && (e != (&vec_q))) begin
      err_d = 1'b1;
      cnt_d = cnt_q + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
      cnt_q <= 5'd0;
    end else begin
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign err       = err_q;
  assign err_count = cnt_q;
`else
  logic unused_e;
  assign unused_e  = e ^ accept;
  assign err       = 1'b0;
  assign err_count = 5'd0;
`endif

endmodule

// File: tb/tb_four_input_stimulus_gen.sv
// Bench for four_input_stimulus_gen: sweep-level reference model checked every cycle plus directed scenarios.
module tb_four_input_stimulus_gen;
  localparam int H  = 4;
  localparam int SW = 16 * H;
`ifdef FOUR_INPUT_STIM_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, start, e;
  logic       a, b, c, d, busy, done, err;
  logic [3:0] vec_idx;
  logic [4:0] err_count;
  int         mode = 0;
  logic       rnd_e = 1'b0;
  int         checks = 0, errors = 0;

  four_input_stimulus_gen #(.HOLD_CYCLES(H)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a), .b(b), .c(c), .d(d), .e(e),
    .vec_idx(vec_idx), .busy(busy), .done(done),
    .err(err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Gate under test: 0 AND, 1 stuck-at-1, 2 OR, 3 random
  always_comb begin
    case (mode)
      0:       e = a & b & c & d;
      1:       e = 1'b1;
      2:       e = a | b | c | d;
      default: e = rnd_e;
    endcase
  end

  always @(posedge clk) begin
    #1 rnd_e = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: m_t = cycles since start acceptance (-1 idle); sweep occupies 0..SW-1, done at SW.
  int m_t = -1, m_cnt = 0;
  bit m_err = 0;
  always @(negedge clk) begin
    int  ev;
    bit  eb, ed;
    if (!rst_n) begin
      m_t = -1; m_err = 0; m_cnt = 0;
    end
    eb = (m_t >= 0) && (m_t < SW);
    ed = (m_t == SW);
    ev = eb ? m_t / H : 0;
    chk("busy", int'(busy), int'(eb));
    chk("done", int'(done), int'(ed));
    chk("vec_idx", int'(vec_idx), ev);
    chk("abcd", int'({a, b, c, d}), ev);
    chk("err", int'(err), int'(m_err));
    chk("err_count", int'(err_count), m_cnt);
    if (rst_n) begin
      if (m_t < 0) begin
        if (start) begin m_t = 0; m_err = 0; m_cnt = 0; end
      end else if (m_t < SW) begin
        if ((m_t % H) == H - 1 && CHK && (e != ((m_t / H) == 15))) begin
          m_err = 1; m_cnt++;
        end
        m_t++;
      end else begin
        m_t = -1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  // Assert start during an IDLE cycle; n = cycle index (start cycle = 0) at which done is seen.
  task automatic sweep(output int n);
    start = 1'b1;
    n = 0;
    while (n < 2000) begin
      tick();
      n++;
      start = 1'b0;
      if (done) break;
    end
    if (!done) timeout("sweep");
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 2000) begin tick(); n++; end
    if (!done) timeout("wait_done");
  endtask

  initial begin
    int n, n2;
    rst_n = 1'b0; start = 1'b0;
    repeat (3) tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_vec", int'(vec_idx), 0);
    chk("rst_cnt", int'(err_count), 0);
    rst_n = 1'b1;
    tick();

    mode = 0; sweep(n);
    chk("and_latency", n, 65);
    tick();
    chk("and_err", int'(err), 0);
    chk("and_cnt", int'(err_count), 0);

    mode = 1; sweep(n);
    chk("const1_latency", n, 65);
    tick();
    chk("const1_err", int'(err), CHK ? 1 : 0);
    chk("const1_cnt", int'(err_count), CHK ? 15 : 0);

    mode = 2; sweep(n);
    tick();
    chk("or_cnt", int'(err_count), CHK ? 14 : 0);
    chk("or_err", int'(err), CHK ? 1 : 0);
    start = 1'b1; tick(); start = 1'b0;
    chk("clear_busy", int'(busy), 1);
    chk("clear_err", int'(err), 0);
    chk("clear_cnt", int'(err_count), 0);
    wait_done(n); tick();

    // Reset mid-sweep with errors accumulated
    mode = 1; start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (vec_idx != 4'd7 && n < 200) begin tick(); n++; end
    if (vec_idx != 4'd7) timeout("reach_vec7");
    rst_n = 1'b0; #1;
    chk("mid_rst_abcd", int'({a, b, c, d}), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_vec", int'(vec_idx), 0);
    chk("mid_rst_cnt", int'(err_count), 0);
    chk("mid_rst_done", int'(done), 0);
    repeat (2) tick();
    rst_n = 1'b1; tick();
    mode = 0; sweep(n);
    chk("post_rst_latency", n, 65);
    tick();

    // start held high: back-to-back sweeps
    start = 1'b1;
    wait_done(n); tick();
    wait_done(n2);
    chk("held_period", n2 + 1, SW + 2);
    start = 1'b0;
    n = 0;
    while ((busy || done) && n < 200) begin tick(); n++; end

    // Randomized traffic, reference model checks every cycle
    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 3);
      start = 1'b1;
      repeat ($urandom_range(1, 3)) tick();
      start = 1'b0;
      repeat ($urandom_range(0, 90)) tick();
      if ($urandom_range(0, 7) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
    end
    repeat (80) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
